// File: rtl/count_mon_pkg.sv
// Shared types for the counter wrap monitor: FSM state encoding and the
// event-code values carried through the event slot.
package count_mon_pkg;

   typedef enum logic {
      ST_PRIME = 1'b0,
      ST_TRACK = 1'b1
   } mon_state_e;

   localparam logic EVT_UNF = 1'b0;
   localparam logic EVT_OVF = 1'b1;

endpackage : count_mon_pkg

// File: rtl/evt_slot.sv
// One-deep valid/ack event holding register. An event arriving while the slot
// is full and not being acked is dropped and latched into the sticky lost flag.
module evt_slot (
   input  logic clk,
   input  logic rst,
   input  logic evt_in,
   input  logic code_in,
   input  logic ack,
   output logic valid,
   output logic code,
   output logic lost
);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         code  <= 1'b0;
         lost  <= 1'b0;
      end else if (evt_in) begin
         // An ack in the same cycle frees the slot, so the new event takes it.
         if (!valid || ack) begin
            valid <= 1'b1;
            code  <= code_in;
         end else begin
            lost  <= 1'b1;
         end
      end else if (ack) begin
         valid <= 1'b0;
      end
   end

endmodule : evt_slot

// File: rtl/count_wrap_monitor.sv
// Watches an up/down counter for overflow/underflow, keeps a saturating signed
// wrap epoch and a threshold match. Optional step checker: COUNT_MON_STEP_CHECK_EN.
module count_wrap_monitor
   import count_mon_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int EPOCH_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               up_down,
   input  logic [WIDTH-1:0]   count,
   input  logic [WIDTH-1:0]   thresh,
   output logic               ovf_pulse,
   output logic               unf_pulse,
   output logic [EPOCH_W-1:0] wrap_epoch,
   output logic               match,
   output logic               evt_valid,
   output logic               evt_code,
   input  logic               evt_ack,
   output logic               evt_lost,
   output logic               step_err
);

   localparam logic [WIDTH-1:0]   CNT_MAX   = '1;
   localparam logic [WIDTH-1:0]   CNT_ONE   = WIDTH'(1);
   localparam logic [EPOCH_W-1:0] EPOCH_ONE = EPOCH_W'(1);
   localparam logic [EPOCH_W-1:0] EPOCH_MAX = {1'b0, {(EPOCH_W-1){1'b1}}};
   localparam logic [EPOCH_W-1:0] EPOCH_MIN = {1'b1, {(EPOCH_W-1){1'b0}}};

   mon_state_e       state_q, state_d;
   logic [WIDTH-1:0] prev_q;
   logic             dir_q;
   logic             ovf, unf;
   logic             step_bad;

`ifdef COUNT_MON_STEP_CHECK_EN
   logic [WIDTH-1:0] step_exp;

   assign step_exp = dir_q ? (prev_q + CNT_ONE) : (prev_q - CNT_ONE);
   assign step_bad = (state_q == ST_TRACK) && (count != step_exp);

   always_ff @(posedge clk) begin
      if (rst)           step_err <= 1'b0;
      else if (step_bad) step_err <= 1'b1;
   end
`else
   assign step_bad = 1'b0;
   assign step_err = 1'b0;
`endif

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      ovf     = 1'b0;
      unf     = 1'b0;
      case (state_q)
         ST_PRIME: state_d = ST_TRACK;
         ST_TRACK: begin
            state_d = ST_TRACK;
            ovf = dir_q  && (prev_q == CNT_MAX) && (count == '0)     && !step_bad;
            unf = !dir_q && (prev_q == '0)      && (count == CNT_MAX) && !step_bad;
         end
         default:  state_d = ST_PRIME;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_PRIME;
         prev_q     <= '0;
         dir_q      <= 1'b1;
         ovf_pulse  <= 1'b0;
         unf_pulse  <= 1'b0;
         match      <= 1'b0;
         wrap_epoch <= '0;
      end else begin
         state_q   <= state_d;
         prev_q    <= count;
         dir_q     <= up_down;
         ovf_pulse <= ovf;
         unf_pulse <= unf;
         match     <= (count == thresh);
         // Saturating epoch: an update past either limit is dropped, the pulse still fires.
         if (ovf && (wrap_epoch != EPOCH_MAX))
            wrap_epoch <= wrap_epoch + EPOCH_ONE;
         else if (unf && (wrap_epoch != EPOCH_MIN))
            wrap_epoch <= wrap_epoch - EPOCH_ONE;
      end
   end

   evt_slot u_evt_slot (
      .clk     (clk),
      .rst     (rst),
      .evt_in  (ovf | unf),
      .code_in (ovf ? EVT_OVF : EVT_UNF),
      .ack     (evt_ack),
      .valid   (evt_valid),
      .code    (evt_code),
      .lost    (evt_lost)
   );

endmodule : count_wrap_monitor

// File: tb/tb_count_wrap_monitor.sv
// Self-checking bench for count_wrap_monitor: the bench plays the 4-bit counter,
// predicts each cycle's outputs into a scoreboard queue and compares after the edge.
module tb_count_wrap_monitor;

   logic       clk = 1'b0;
   logic       rst, up_down, evt_ack;
   logic [3:0] count, thresh;
   logic       ovf_pulse, unf_pulse, match, evt_valid, evt_code, evt_lost, step_err;
   logic [7:0] wrap_epoch;

   always #5 clk = ~clk;

   count_wrap_monitor #(.WIDTH(4), .EPOCH_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .up_down    (up_down),
      .count      (count),
      .thresh     (thresh),
      .ovf_pulse  (ovf_pulse),
      .unf_pulse  (unf_pulse),
      .wrap_epoch (wrap_epoch),
      .match      (match),
      .evt_valid  (evt_valid),
      .evt_code   (evt_code),
      .evt_ack    (evt_ack),
      .evt_lost   (evt_lost),
      .step_err   (step_err)
   );

   typedef struct packed {
      logic       ovf;
      logic       unf;
      logic [7:0] epoch;
      logic       match;
      logic       valid;
      logic       code;
      logic       lost;
      logic       serr;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Reference state: what the bench knows about the counter it is driving.
   bit m_primed, m_valid, m_code, m_lost, m_serr, m_jump;
   int m_epoch, m_wrap;
   int jump_to = -1;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic predict();
      exp_t e;
      bit   ev, ev_code;
      e = '0;
      if (rst) begin
         m_primed = 0; m_epoch = 0; m_valid = 0; m_code = 0; m_lost = 0; m_serr = 0;
      end else begin
         ev = 0; ev_code = 0;
         if (m_primed) begin
`ifdef COUNT_MON_STEP_CHECK_EN
            if (m_jump) m_serr = 1;
`endif
            if (m_wrap == 1) begin
               ev = 1; ev_code = 1; e.ovf = 1;
               if (m_epoch < 127) m_epoch++;
            end else if (m_wrap == -1) begin
               ev = 1; ev_code = 0; e.unf = 1;
               if (m_epoch > -128) m_epoch--;
            end
         end
         if (ev) begin
            if (!m_valid || evt_ack) begin m_valid = 1; m_code = ev_code; end
            else m_lost = 1;
         end else if (evt_ack) begin
            m_valid = 0;
         end
         m_primed = 1;
         e.match = (count == thresh);
      end
      e.epoch = 8'(m_epoch);
      e.valid = m_valid;
      e.code  = m_code;
      e.lost  = m_lost;
      e.serr  = m_serr;
      sb.push_back(e);
   endtask

   // The counter's own edge: reset to 0, step by direction, or a forced jump.
   task automatic advance();
      m_wrap = 0;
      m_jump = 0;
      if (rst) count = 4'd0;
      else if (jump_to >= 0) begin count = 4'(jump_to); jump_to = -1; m_jump = 1; end
      else if (up_down) begin if (count == 4'd15) m_wrap = 1;  count = count + 4'd1; end
      else              begin if (count == 4'd0)  m_wrap = -1; count = count - 4'd1; end
   endtask

   task automatic step();
      exp_t e;
      predict();
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("ovf_pulse",  {7'd0, ovf_pulse}, {7'd0, e.ovf});
      check("unf_pulse",  {7'd0, unf_pulse}, {7'd0, e.unf});
      check("wrap_epoch", wrap_epoch,        e.epoch);
      check("match",      {7'd0, match},     {7'd0, e.match});
      check("evt_valid",  {7'd0, evt_valid}, {7'd0, e.valid});
      if (e.valid) check("evt_code", {7'd0, evt_code}, {7'd0, e.code});
      check("evt_lost",   {7'd0, evt_lost},  {7'd0, e.lost});
      check("step_err",   {7'd0, step_err},  {7'd0, e.serr});
      advance();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; up_down = 1'b1; evt_ack = 1'b0; thresh = 4'd5; count = 4'd0;
      m_wrap = 0; m_jump = 0;
      step();
      step();
      check("rst_all_zero", {ovf_pulse, unf_pulse, match, evt_valid, evt_code, evt_lost, step_err, 1'b0}, 8'h00);
      check("rst_epoch", wrap_epoch, 8'h00);

      // Overflow 15->0, then ack clears the slot.
      rst = 1'b0;
      repeat (17) step();
      check("ovf_seen",   {7'd0, ovf_pulse}, 8'h01);
      check("ovf_epoch",  wrap_epoch, 8'h01);
      check("ovf_code",   {7'd0, evt_code}, 8'h01);
      up_down = 1'b0; evt_ack = 1'b1;
      step();
      evt_ack = 1'b0;
      check("ack_clears", {7'd0, evt_valid}, 8'h00);

      // Underflow 0->15 brings the epoch back to zero.
      step();
      step();
      check("unf_seen",   {7'd0, unf_pulse}, 8'h01);
      check("unf_epoch",  wrap_epoch, 8'h00);
      check("unf_code",   {7'd0, evt_code}, 8'h00);

      // Threshold match: one cycle after count==thresh.
      up_down = 1'b1;
      for (int i = 0; i < 20 && count != thresh; i++) step();
      step();
      check("match_hit",  {7'd0, match}, 8'h01);
      step();
      check("match_gone", {7'd0, match}, 8'h00);

      // Lost event: slot holds the ovf, the later unf is dropped.
      do_reset();
      up_down = 1'b1;
      repeat (17) step();
      up_down = 1'b0;
      repeat (3) step();
      check("lost_set",   {7'd0, evt_lost}, 8'h01);
      check("lost_kept",  {7'd0, evt_code}, 8'h01);
      repeat (5) step();
      check("lost_sticky", {7'd0, evt_lost}, 8'h01);

      // Same pattern with ack on the second event's cycle: replacement, no loss.
      do_reset();
      up_down = 1'b1;
      repeat (17) step();
      up_down = 1'b0;
      repeat (2) step();
      evt_ack = 1'b1;
      step();
      evt_ack = 1'b0;
      check("replace_valid", {7'd0, evt_valid}, 8'h01);
      check("replace_code",  {7'd0, evt_code},  8'h00);
      check("replace_lost",  {7'd0, evt_lost},  8'h00);

      // Positive saturation: the 129th overflow still pulses, epoch holds 127.
      do_reset();
      up_down = 1'b1; evt_ack = 1'b1;
      repeat (2065) step();
      check("sat_pos_pulse", {7'd0, ovf_pulse}, 8'h01);
      check("sat_pos_epoch", wrap_epoch, 8'h7f);

      // Negative saturation at -128.
      do_reset();
      up_down = 1'b0;
      repeat (2050) step();
      check("sat_neg_pulse", {7'd0, unf_pulse}, 8'h01);
      check("sat_neg_epoch", wrap_epoch, 8'h80);

      // Illegal step 3->7.
      do_reset();
      up_down = 1'b1; evt_ack = 1'b0;
      for (int i = 0; i < 20 && count != 4'd3; i++) step();
      jump_to = 7;
      step();
      step();
`ifdef COUNT_MON_STEP_CHECK_EN
      check("jump_step_err", {7'd0, step_err}, 8'h01);
`else
      check("jump_step_err", {7'd0, step_err}, 8'h00);
`endif
      check("jump_no_pulse", {6'd0, ovf_pulse, unf_pulse}, 8'h00);

      // Reset mid-run with a pending event.
      repeat (12) step();
      check("pre_rst_valid", {7'd0, evt_valid}, 8'h01);
      rst = 1'b1;
      step();
      check("midrst_flags", {ovf_pulse, unf_pulse, match, evt_valid, evt_code, evt_lost, step_err, 1'b0}, 8'h00);
      check("midrst_epoch", wrap_epoch, 8'h00);
      rst = 1'b0;
      repeat (4) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_count_wrap_monitor

// File: doc/count_wrap_monitor.md
Name: count_wrap_monitor

Overview:
- Downstream consumer of the 4-bit up/down counter. Taps `count` and `up_down`, detects overflow (MAX->0 counting up) and underflow (0->MAX counting down), and tracks a saturating signed wrap epoch.
- Raises a registered threshold match and queues wrap events into a one-deep valid/ack slot for a CPU-side or logging stage.

Parameters:
- WIDTH, 4, counter width; must be >= 2.
- EPOCH_W, 8, width of signed wrap-epoch accumulator.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset; shared with the counter.
- up_down  in  1  counter direction; 1 = up, 0 = down.
- count  in  WIDTH  counter output.
- thresh  in  WIDTH  match threshold, quasi-static.
- ovf_pulse  out  1  one-cycle overflow strobe.
- unf_pulse  out  1  one-cycle underflow strobe.
- wrap_epoch  out  EPOCH_W  signed; +1 per overflow, -1 per underflow, saturating.
- match  out  1  registered (count == thresh).
- evt_valid  out  1  event slot occupied.
- evt_code  out  1  1 = overflow, 0 = underflow; valid while evt_valid.
- evt_ack  in  1  consumer accepts event.
- evt_lost  out  1  sticky; an event arrived while the slot was full and un-acked.
- step_err  out  1  sticky step-check error; tied 0 when the feature is compiled out.

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0, wrap_epoch 0, prev_q 0, dir_q 1, FSM to PRIME. The counter resets to 0 on the same edge.
- Sampling, every edge: prev_q <= count; dir_q <= up_down.
  - At edge k+1, `count` is the result of the counter's edge k.
  - prev_q is the pre-edge-k value; dir_q is the direction used at edge k.
- FSM PRIME -> TRACK:
  - PRIME lasts exactly the first edge after reset is released. It loads prev_q/dir_q, emits no events and runs no checks.
  - TRACK stays until rst.
- Detection, in TRACK only:
  - ovf = dir_q & (prev_q == 2^WIDTH-1) & (count == 0).
  - unf = ~dir_q & (prev_q == 0) & (count == 2^WIDTH-1).
  - ovf_pulse/unf_pulse are registered and assert on the edge after the wrapped value appears, for exactly one cycle.
- wrap_epoch:
  - Updated on the same edge as the pulse.
  - Saturates at +(2^(EPOCH_W-1)-1) and at -(2^(EPOCH_W-1)).
  - Updates that would exceed the limit are dropped; pulses still fire.
- match: registered every cycle, including PRIME; 1-cycle latency. Independent of the event slot.
- Event slot, valid/ack:
  - A new event loads the slot (evt_valid=1, evt_code set).
  - evt_ack while evt_valid clears the slot on the next edge.
  - New event with slot full and evt_ack=1 in the same cycle: the new event replaces the old one, evt_valid stays 1, nothing is lost.
  - New event with slot full and evt_ack=0: the existing event is kept, the new one is dropped, evt_lost <= 1.
  - evt_ack while the slot is empty is ignored.
- Sticky flags: evt_lost and step_err clear only on rst.
- Reset mid-operation: pending event discarded, epoch cleared, back to PRIME.

Optional Feature:
- COUNT_MON_STEP_CHECK_EN defined:
  - In TRACK, the expected value is (prev_q + (dir_q ? 1 : -1)) mod 2^WIDTH.
  - If count differs from it, step_err <= 1 and ovf/unf are suppressed for that cycle.
- Not defined: no check logic, step_err tied 0, and wrap classification uses only the equations above.

Decomposition:
- Package count_mon_pkg: FSM state enum (PRIME, TRACK), event code constants EVT_UNF=0 and EVT_OVF=1.
- Sub-module evt_slot: one-deep valid/ack holding register with lost-event detection. It is natural and reusable.
- Top level holds sampling, FSM, detection, epoch and match.

Test Plan (WIDTH=4, EPOCH_W=8):
1. Release reset with up_down=1 and run 16 clocks. Count 15->0 -> ovf_pulse for one cycle the edge after count=0 appears, wrap_epoch=1, evt_valid=1 with evt_code=1. Ack it -> evt_valid=0 next edge.
2. From count=0, set up_down=0 and run 1 clock. Count goes to 15 -> unf_pulse, wrap_epoch returns to 0, evt_code=0.
3. thresh=5, counting up. Count=5 at cycle N -> match=1 at N+1 only.
4. Never ack. Produce an ovf, then 16 clocks later a second ovf -> evt_valid stays 1 with the first event, evt_lost=1 and stays set. Repeat with evt_ack=1 on the second event's cycle -> evt_lost stays 0.
5. Force wrap_epoch to 127 with 128 overflows -> the next ovf pulses but wrap_epoch holds 127.
6. With COUNT_MON_STEP_CHECK_EN, drive count 3->7 directly -> step_err=1, no pulse. Without the macro, step_err stays 0. Assert rst mid-run -> all outputs 0 the next edge.
